// File: rtl/except_pkg.sv
`default_nettype none
// except_pkg: sequencer states, commit-stage exception type codes, CP0 ExcCodes
// and the legality/ExcCode mapping helpers shared by except_ctrl.
package except_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } exc_state_t;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] EXCODE_INT  = 5'd0;
  localparam logic [4:0] EXCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCODE_ADES = 5'd5;
  localparam logic [4:0] EXCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCODE_BP   = 5'd9;
  localparam logic [4:0] EXCODE_RI   = 5'd10;
  localparam logic [4:0] EXCODE_OV   = 5'd12;

  function automatic logic exc_legal(input logic [31:0] t);
    case (t)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV, EXC_ERET: exc_legal = 1'b1;
      default:                          exc_legal = 1'b0;
    endcase
  endfunction

  // Interrupts report ExcCode 0; every other type carries its own low bits.
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    exc_code = (t == EXC_INT) ? EXCODE_INT : t[4:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/except_ctrl.sv
`default_nettype none
// except_ctrl: sequences a committed exception/ERET through pipeline flush, bus
// drain, a single CP0 write and a valid/ready redirect to fetch.
module except_ctrl
  import except_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'hBFC00380,
  parameter int          DRAIN_MAX   = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        except_valid,
  input  logic [31:0] excepttype,
  input  logic [31:0] except_inst_addr,
  input  logic [31:0] except_bad_addr,
  input  logic        except_in_delayslot,
  input  logic [31:0] except_target,
  input  logic        mem_busy,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        stall_commit,
  output logic        cp0_exc_we,
  output logic        cp0_eret_we,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_epc,
  output logic [4:0]  cp0_excode,
  output logic        cp0_bd,
  output logic [31:0] cp0_badvaddr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout,
  output logic        busy
);

  localparam int              CW      = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DRAIN_MAX);

  exc_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   epc_q, badvaddr_q, target_q, redirect_pc_q;
  logic [4:0]    excode_q;
  logic          bd_q, is_eret_q, is_adex_q;
  logic          flush_q, exc_we_q, eret_we_q, bva_we_q, rv_q, timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      target_q      <= '0;
      redirect_pc_q <= '0;
      excode_q      <= '0;
      bd_q          <= 1'b0;
      is_eret_q     <= 1'b0;
      is_adex_q     <= 1'b0;
      flush_q       <= 1'b0;
      exc_we_q      <= 1'b0;
      eret_we_q     <= 1'b0;
      bva_we_q      <= 1'b0;
      rv_q          <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      exc_we_q  <= 1'b0;
      eret_we_q <= 1'b0;
      bva_we_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (except_valid && exc_legal(excepttype)) begin
            epc_q      <= except_in_delayslot ? except_inst_addr - 32'd4 : except_inst_addr;
            bd_q       <= except_in_delayslot;
            excode_q   <= exc_code(excepttype);
            badvaddr_q <= except_bad_addr;
            target_q   <= (excepttype == EXC_ERET) ? except_target : VECTOR_BASE;
            is_eret_q  <= (excepttype == EXC_ERET);
            is_adex_q  <= (excepttype == EXC_ADEL) || (excepttype == EXC_ADES);
            cnt_q      <= '0;
            flush_q    <= 1'b1;
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (!mem_busy || cnt_q == CNT_MAX) begin
            // A simultaneous idle bus and counter limit counts as a clean drain.
            timeout_q <= mem_busy;
            exc_we_q  <= !is_eret_q;
            eret_we_q <= is_eret_q;
            bva_we_q  <= is_adex_q;
            state_q   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          rv_q          <= 1'b1;
          redirect_pc_q <= target_q;
          state_q       <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flush           = flush_q;
  assign stall_commit    = flush_q;
  assign busy            = flush_q;
  assign cp0_exc_we      = exc_we_q;
  assign cp0_eret_we     = eret_we_q;
  assign cp0_badvaddr_we = bva_we_q;
  assign cp0_epc         = epc_q;
  assign cp0_excode      = excode_q;
  assign cp0_bd          = bd_q;
  assign cp0_badvaddr    = badvaddr_q;
  assign redirect_valid  = rv_q;
  assign redirect_pc     = redirect_pc_q;
  assign drain_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: doc/except_ctrl.md
# except_ctrl

Sequencer that turns a committed exception or ERET decision from the commit-stage exception decoder into an ordered multi-cycle action. It latches the exception, flushes the dual-issue pipeline, drains outstanding data-bus transactions, writes CP0 once, and hands a redirect PC to fetch over a valid/ready handshake. It sits between the commit-stage exception decoder, CP0 and the fetch unit.

## Interface
- `VECTOR_BASE`, default 32'hBFC00380: general exception vector.
- `DRAIN_MAX`, default 255: maximum number of DRAIN cycles before the drain is forced to end. Counter width is $clog2(DRAIN_MAX+1).
- `clk` in 1: clock. All logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `except_valid` in 1: commit stage has a nonzero `excepttype` this cycle.
- `excepttype` in 32: exception code from the decoder. Legal values are 1, 4, 5, 8, 9, 0xa, 0xc, 0xe.
- `except_inst_addr` in 32: PC of the faulting instruction.
- `except_bad_addr` in 32: faulting address for address errors.
- `except_in_delayslot` in 1: the faulting instruction is in a branch delay slot.
- `except_target` in 32: ERET return address (EPC).
- `mem_busy` in 1: a data-bus transaction is outstanding.
- `redirect_ready` in 1: fetch accepts the redirect.
- `flush` out 1: kill all in-flight instructions.
- `stall_commit` out 1: block commit.
- `cp0_exc_we` out 1: one-cycle strobe. CP0 writes EPC, Cause.ExcCode and Cause.BD, and sets Status.EXL.
- `cp0_eret_we` out 1: one-cycle strobe that clears Status.EXL.
- `cp0_badvaddr_we` out 1: one-cycle strobe that writes BadVAddr.
- `cp0_epc` out 32, `cp0_excode` out 5, `cp0_bd` out 1, `cp0_badvaddr` out 32: CP0 write data.
- `redirect_valid` out 1, `redirect_pc` out 32: redirect to fetch.
- `drain_timeout` out 1: one-cycle pulse when DRAIN ends by timeout.
- `busy` out 1: the state is not IDLE.

## Operation
- **States:** IDLE, DRAIN, COMMIT, REDIRECT.
- **IDLE:** if `except_valid` is high and `excepttype` is legal, capture all inputs and go to DRAIN.
  - An illegal `excepttype` is ignored and the block stays in IDLE.
  - `except_valid` is ignored in every non-IDLE state. There is no nesting.
- **Captured fields:**
  - EPC = `except_in_delayslot` ? `except_inst_addr` − 4 : `except_inst_addr`, computed modulo 2^32. Example: 0 − 4 = 32'hFFFFFFFC.
  - BD = `except_in_delayslot`.
  - ExcCode = `excepttype[4:0]`, except that type 1 (interrupt) maps to 0.
  - Target = `except_target` for type 0xe; `VECTOR_BASE` for all other types.
- **DRAIN:**
  - `flush`=1 and `stall_commit`=1.
  - The drain counter increments every DRAIN cycle.
  - Exit to COMMIT when `mem_busy`=0, or when counter = DRAIN_MAX.
  - If the exit is by timeout, pulse `drain_timeout` in that same cycle.
  - If `mem_busy`=0 and the counter hits DRAIN_MAX in the same cycle, it is a normal exit and there is no timeout pulse.
- **COMMIT** (exactly one cycle):
  - For type 0xe: `cp0_eret_we`=1.
  - For all other types: `cp0_exc_we`=1.
  - Additionally, `cp0_badvaddr_we`=1 for types 4 and 5 only.
  - The CP0 data outputs carry the captured values.
  - Next state is REDIRECT.
- **REDIRECT:**
  - `redirect_valid`=1 and `redirect_pc` = captured target.
  - Both are held stable until the cycle in which `redirect_ready`=1, then the block returns to IDLE.
- **Flush and stall:** `flush`=1 and `stall_commit`=1 in DRAIN, COMMIT and REDIRECT.
- **Reset:**
  - Asserting `resetn`=0 in any state forces IDLE asynchronously.
  - All outputs are 0 during and immediately after reset.
  - The CP0 data outputs and `redirect_pc` also reset to 0.
  - A redirect that has not been accepted is abandoned.

## Timing
- **Capture:** the exception is captured at edge T, where `except_valid`=1 in the cycle before T.
- **Normal sequence:** DRAIN is cycle T..T+1. COMMIT is T+1..T+2 when `mem_busy`=0 in the first DRAIN cycle.
- **REDIRECT entry:** REDIRECT starts at T+2. With `redirect_ready`=1, the block is in IDLE from T+3.
- **Minimum latency:** from exception to accepted redirect is 3 cycles.
- **Registered outputs:** all outputs decode from the state and captured registers only. There is no combinational path from the inputs.
- **Back-to-back exceptions:** a new exception can be captured in the first IDLE cycle after REDIRECT completes.

## Structure
- **Package `except_pkg`:**
  - state enum `exc_state_t`.
  - excepttype constants: EXC_INT=1, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=0xa, EXC_OV=0xc, EXC_ERET=0xe.
  - CP0 ExcCode constants.
  - a `exc_legal()` function.
- **Sub-modules:** none. The field computation is a single always_ff capture block.

## Test plan
- **Syscall:** type 8, pc 32'hBFC01000, not in a delay slot, `mem_busy`=0, `redirect_ready`=1.
  - Required: `cp0_exc_we` at T+1 with EPC 32'hBFC01000, ExcCode 8, BD 0.
  - `redirect_pc` 32'hBFC00380 at T+2; `busy` low at T+3.
- **AdEL in a delay slot:** type 4, pc 32'h80000010, bad address 32'h80000123.
  - Required: EPC 32'h8000000C, BD 1, `cp0_badvaddr_we`=1 with 32'h80000123.
- **ERET:** type 0xe, `except_target` 32'h80001234.
  - Required: `cp0_eret_we`=1, `cp0_exc_we`=0.
  - `redirect_pc` 32'h80001234.
- **Drain:** `mem_busy` high for 5 cycles.
  - Required: COMMIT in the 6th DRAIN-exit cycle, `drain_timeout`=0.
  - With `mem_busy` stuck high and DRAIN_MAX=3: `drain_timeout` pulses once and COMMIT still occurs.
- **Redirect hold:** `redirect_ready` low for 4 cycles.
  - Required: `redirect_valid` and `redirect_pc` are stable throughout.
  - A second `except_valid` in that window is ignored.
- **Edge cases:**
  - `resetn` low during REDIRECT: all outputs are 0 immediately, and the block is in IDLE after release.
  - Illegal type 2: no state change.
  - Interrupt at pc 0 in a delay slot: EPC 32'hFFFFFFFC, ExcCode 0.
